fetch_queue: RTL and testbench

Parametrised fetch stage with a decoupled instruction queue. Issues sequential PC requests to instruction memory over a valid/ready request channel, accepts in-order responses of arbitrary latency, and buffers them in a DEPTH-entry FIFO. Decode drains the FIFO with a valid/ready handshake. A branch/jump redirect from execute flushes the queue and discards in-flight responses. Sits between imem and decode; replaces the single-register fetch stage.

---
 rtl/fetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry instruction queue, credit-based imem requests and redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect raises misaligned_o and halts fetch.
module fetch_queue #(
    parameter int unsigned         DWIDTH         = 32,
    parameter int unsigned         AWIDTH         = 32,
    parameter logic [AWIDTH-1:0]   IMEM_BASE_ADDR = '0,
    parameter logic [AWIDTH-1:0]   RESET_PC       = IMEM_BASE_ADDR,
    parameter int unsigned         DEPTH          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pcsel_i,
    input  logic [AWIDTH-1:0] pc_branch_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [AWIDTH-1:0] imem_req_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [DWIDTH-1:0] imem_rsp_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [AWIDTH-1:0] pc_o,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic              misaligned_o,
`endif
    output logic [DWIDTH-1:0] insn_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [DWIDTH-1:0] INSN_NOP = DWIDTH'(32'h0000_0013);

    logic [AWIDTH-1:0] fetch_pc;
    logic [AWIDTH-1:0] rsp_pc;
    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     discard;
    logic [CW:0]       inflight;
    logic [AWIDTH-1:0] target;
    logic              halted;
    logic              accept;
    logic              push;
    logic              drop;
    logic              pop;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;

    // Sticky trap flag, re-evaluated on every redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (pcsel_i) begin
            misaligned <= |pc_branch_i[1:0];
        end
    end

    assign misaligned_o = misaligned;
    assign halted       = misaligned;
`else
    assign halted = 1'b0;
`endif

    // Redirect targets are always word aligned inside the queue.
    assign target = pc_branch_i & ~AWIDTH'(3);

    // Credit check guarantees a free slot for every response in flight.
    assign inflight         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid_o = !rst && !pcsel_i && !halted && (inflight < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = fetch_pc;

    assign accept          = imem_req_valid_o && imem_req_ready_i;
    assign drop            = imem_rsp_valid_i && (discard != '0);
    assign push            = imem_rsp_valid_i && (discard == '0) && !pcsel_i;
    assign pop             = valid_o && ready_i;
    assign outstanding_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid_i);

    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? pc_mem[rd_ptr]   : fetch_pc;
    assign insn_o  = valid_o ? insn_mem[rd_ptr] : INSN_NOP;

    // Control state: fetch PC, queue pointers and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (pcsel_i) begin
                fetch_pc <= target;
                rsp_pc   <= target;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                discard  <= outstanding_nxt;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + AWIDTH'(4);
                end
                if (drop) begin
                    discard <= discard - CW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                    rsp_pc <= rsp_pc + AWIDTH'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage needs no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= rsp_pc;
            insn_mem[wr_ptr] <= imem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a fixed-latency in-order imem model.
// Build with FETCH_MISALIGN_TRAP_EN to exercise the misaligned-redirect trap.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcsel;
    logic [31:0] pc_branch;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        valid;
    logic        ready;
    logic [31:0] pc;
    logic [31:0] insn;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;

    int          due_q[$];
    logic [31:0] adr_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] del_pc[$];
    logic [31:0] del_insn[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk              (clk),
        .rst              (rst),
        .pcsel_i          (pcsel),
        .pc_branch_i      (pc_branch),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .valid_o          (valid),
        .ready_i          (ready),
        .pc_o             (pc),
`ifdef FETCH_MISALIGN_TRAP_EN
        .misaligned_o     (misaligned),
`endif
        .insn_o           (insn)
    );

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive the due response, log accepts and deliveries, advance to next negedge.
    task automatic cycle();
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_data(adr_q[0]);
            void'(due_q.pop_front());
            void'(adr_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = '0;
        end
        #1;
        if (req_valid && req_ready) begin
            acc_q.push_back(req_addr);
            due_q.push_back(cyc + lat);
            adr_q.push_back(req_addr);
        end
        if (valid && ready) begin
            del_pc.push_back(pc);
            del_insn.push_back(insn);
        end
        @(negedge clk);
        cyc++;
        pcsel = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        pcsel     = 1'b1;
        pc_branch = t;
        cycle();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        pcsel     = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        due_q.delete();
        adr_q.delete();
        acc_q.delete();
        del_pc.delete();
        del_insn.delete();
    endtask

    task automatic wait_del(input int n, input int budget, input string tag);
        int k = 0;
        while (del_pc.size() < n && k < budget) begin
            cycle();
            k++;
        end
        check(tag, 64'(del_pc.size() >= n), 64'd1);
    endtask

    // Compare delivered stream [first, first+n) against consecutive PCs from base.
    task automatic check_stream(input int first, input int n, input logic [31:0] base, input string tag);
        for (int i = 0; i < n; i++) begin
            if (first + i < del_pc.size()) begin
                check($sformatf("%s_pc%0d", tag, i), 64'(del_pc[first+i]), 64'(base + 32'(4*i)));
                check($sformatf("%s_insn%0d", tag, i), 64'(del_insn[first+i]),
                      64'(mem_data(base + 32'(4*i))));
            end else begin
                check($sformatf("%s_missing%0d", tag, i), 64'(del_pc.size()), 64'(first + n));
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        pcsel     = 1'b0;
        pc_branch = '0;
        req_ready = 1'b1;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        ready     = 1'b1;
        lat       = 1;
        repeat (2) @(negedge clk);

        // Reset values while rst is held.
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_req_valid", 64'(req_valid), 64'd0);
        check("rst_pc", 64'(pc), 64'h0);
        check("rst_insn", 64'(insn), 64'h13);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_misaligned", 64'(misaligned), 64'd0);
`endif

        // 1-cycle memory, decode always ready: valid_o from cycle 2, full throughput.
        rst = 1'b0;
        cyc = 0;
        check("t1_valid_c0", 64'(valid), 64'd0);
        cycle();
        check("t1_valid_c1", 64'(valid), 64'd0);
        cycle();
        check("t1_valid_c2", 64'(valid), 64'd1);
        check("t1_pc_c2", 64'(pc), 64'h0);
        repeat (6) cycle();
        check("t1_del_count", 64'(del_pc.size()), 64'd6);
        check_stream(0, 6, 32'h0, "t1");
        check("t1_acc0", 64'(acc_q[0]), 64'h0);
        check("t1_acc1", 64'(acc_q[1]), 64'h4);
        check("t1_acc2", 64'(acc_q[2]), 64'h8);

        // Decode stalled: exactly DEPTH requests, then resume in order.
        do_reset();
        ready = 1'b0;
        repeat (10) cycle();
        check("t2_acc_count", 64'(acc_q.size()), 64'd4);
        check("t2_req_valid", 64'(req_valid), 64'd0);
        check("t2_valid", 64'(valid), 64'd1);
        check("t2_head_pc", 64'(pc), 64'h0);
        ready = 1'b1;
        repeat (10) cycle();
        check("t2_del_ge8", 64'(del_pc.size() >= 8), 64'd1);
        check_stream(0, 8, 32'h0, "t2");

        // 3-cycle memory, redirect with two requests outstanding.
        do_reset();
        lat = 3;
        repeat (2) cycle();
        redirect(32'h100);
        wait_del(2, 30, "t3_wait");
        check_stream(0, 2, 32'h100, "t3");
        check("t3_acc2", 64'(acc_q[2]), 64'h100);

        // Redirect coincident with a response and a pop.
        do_reset();
        lat = 1;
        repeat (4) cycle();
        redirect(32'h300);
        check("t4_valid_after", 64'(valid), 64'd0);
        check("t4_pc_after", 64'(pc), 64'h300);
        wait_del(5, 30, "t4_wait");
        check_stream(0, 3, 32'h0, "t4_old");
        check_stream(3, 2, 32'h300, "t4_new");

        // Fetch PC wraps at the top of the address space.
        do_reset();
        redirect(32'hFFFF_FFF8);
        wait_del(3, 30, "t5_wait");
        check("t5_acc0", 64'(acc_q[0]), 64'hFFFF_FFF8);
        check("t5_acc1", 64'(acc_q[1]), 64'hFFFF_FFFC);
        check("t5_acc2", 64'(acc_q[2]), 64'h0);
        check("t5_del2", 64'(del_pc[2]), 64'h0);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect halts fetch until an aligned redirect.
        do_reset();
        redirect(32'h102);
        check("t6_misaligned_set", 64'(misaligned), 64'd1);
        repeat (3) cycle();
        check("t6_no_req", 64'(acc_q.size()), 64'd0);
        check("t6_req_valid", 64'(req_valid), 64'd0);
        redirect(32'h200);
        check("t6_misaligned_clr", 64'(misaligned), 64'd0);
        wait_del(1, 30, "t6_wait");
        check("t6_acc0", 64'(acc_q[0]), 64'h200);
        check("t6_del0", 64'(del_pc[0]), 64'h200);
`else
        // Without the trap, the low target bits are ignored.
        do_reset();
        redirect(32'h102);
        wait_del(1, 30, "t6_wait");
        check("t6_acc0", 64'(acc_q[0]), 64'h100);
        check("t6_del0", 64'(del_pc[0]), 64'h100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
